// File: rtl/ptw_pt_mem_responder_if.sv
// Dcache request port between the page-table walker (master) and its memory
// responder (slave). Signal names keep the responder-side direction suffix so
// they line up with the responder's port list.
//   data_req_i/address_*_i/data_we_i/data_be_i/data_size_i/data_wdata_i : request
//   kill_req_i   : squash all in-flight reads
//   data_gnt_o   : request accepted this cycle
//   data_rvalid_o/data_rdata_o : read response
//   err_o        : illegal access (qualifies rvalid or a write grant)
interface ptw_pt_mem_responder_if #(
    parameter int XLEN    = 64,
    parameter int INDEX_W = 12,
    parameter int TAG_W   = 44
);
    logic                 data_req_i;
    logic [INDEX_W-1:0]   address_index_i;
    logic [TAG_W-1:0]     address_tag_i;
    logic                 data_we_i;
    logic [XLEN/8-1:0]    data_be_i;
    logic [1:0]           data_size_i;
    logic [XLEN-1:0]      data_wdata_i;
    logic                 kill_req_i;
    logic                 data_gnt_o;
    logic                 data_rvalid_o;
    logic [XLEN-1:0]      data_rdata_o;
    logic                 err_o;

    modport master (
        output data_req_i, address_index_i, address_tag_i, data_we_i,
               data_be_i, data_size_i, data_wdata_i, kill_req_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, err_o
    );

    modport slave (
        input  data_req_i, address_index_i, address_tag_i, data_we_i,
               data_be_i, data_size_i, data_wdata_i, kill_req_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, err_o
    );
endinterface

// File: rtl/ptw_pt_mem_responder.sv
// Page-table memory responder for the PTW dcache port.
// Grants reads and byte-masked writes, answers every granted read with exactly
// one rvalid RESP_LAT cycles after the grant (in grant order), and limits the
// number of unanswered reads to MAX_OUTSTANDING. Killed reads still answer, with
// zero data and no error. A backdoor port loads whole words and blocks grants.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   bus (slave)          : dcache request/response port
//   stall_i              : withhold grants
//   init_we_i/addr/wdata : backdoor word write
//   busy_o               : any read in flight
module ptw_pt_mem_responder #(
    parameter int          XLEN            = 64,
    parameter int          INDEX_W         = 12,
    parameter int          TAG_W           = 44,
    parameter int          MEM_DEPTH       = 512,
    parameter logic [63:0] BASE_ADDR       = 64'h8000_0000,
    parameter int          RESP_LAT        = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    ptw_pt_mem_responder_if.slave         bus,
    input  logic                          stall_i,
    input  logic                          init_we_i,
    input  logic [$clog2(MEM_DEPTH)-1:0]  init_addr_i,
    input  logic [XLEN-1:0]               init_wdata_i,
    output logic                          busy_o
);
    localparam int PLEN = TAG_W + INDEX_W;
    localparam int AW   = $clog2(MEM_DEPTH);
    localparam int BW   = XLEN / 8;
    localparam int S    = RESP_LAT - 1;
    localparam int CW   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PLEN-1:0] BASE_P = BASE_ADDR[PLEN-1:0];

    logic [XLEN-1:0] mem [MEM_DEPTH];

    logic [PLEN-1:0] paddr, off;
    logic [AW-1:0]   word;
    logic            legal, gnt, rd_fire, wr_fire;
    logic [CW-1:0]   outst;

    logic [S:0]           vld_pipe, kill_pipe, err_pipe;
    logic [S:0][XLEN-1:0] data_pipe;

    assign paddr = {bus.address_tag_i, bus.address_index_i};
    assign off   = paddr - BASE_P;
    assign word  = off[3 +: AW];
    assign legal = (paddr >= BASE_P) && ((off >> 3) < PLEN'(MEM_DEPTH)) &&
                   (paddr[2:0] == 3'd0) && (bus.data_size_i == 2'd3);

    // Slot check uses the registered count only: an rvalid this cycle does not
    // free a slot for a grant in the same cycle.
    assign gnt     = bus.data_req_i & ~stall_i & ~init_we_i &
                     (bus.data_we_i | (outst < CW'(MAX_OUTSTANDING)));
    assign rd_fire = gnt & ~bus.data_we_i;
    assign wr_fire = gnt & bus.data_we_i & legal;

    assign bus.data_gnt_o    = gnt;
    assign bus.data_rvalid_o = vld_pipe[S];
    assign bus.data_rdata_o  = kill_pipe[S] ? '0 : data_pipe[S];
    // Read error qualifies rvalid; write error qualifies the write grant.
    assign bus.err_o         = (vld_pipe[S] & err_pipe[S] & ~kill_pipe[S]) |
                               (gnt & bus.data_we_i & ~legal);
    assign busy_o            = (outst != '0);

    // Memory is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (init_we_i) begin
            mem[init_addr_i] <= init_wdata_i;
        end else if (wr_fire) begin
            for (int k = 0; k < BW; k++) begin
                if (bus.data_be_i[k]) mem[word][8*k +: 8] <= bus.data_wdata_i[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe  <= '0;
            kill_pipe <= '0;
            err_pipe  <= '0;
            data_pipe <= '0;
            outst     <= '0;
        end else begin
            vld_pipe[0]  <= rd_fire;
            kill_pipe[0] <= rd_fire & bus.kill_req_i;
            err_pipe[0]  <= rd_fire & ~legal;
            data_pipe[0] <= (rd_fire && legal) ? mem[word] : '0;
            // Kill tags every read still travelling; the one leaving the final
            // stage this cycle has already been presented.
            for (int i = 1; i <= S; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                kill_pipe[i] <= kill_pipe[i-1] | (vld_pipe[i-1] & bus.kill_req_i);
                err_pipe[i]  <= err_pipe[i-1];
                data_pipe[i] <= data_pipe[i-1];
            end
            case ({rd_fire, vld_pipe[S]})
                2'b10:   outst <= outst + CW'(1);
                2'b01:   outst <= outst - CW'(1);
                default: outst <= outst;
            endcase
        end
    end
endmodule
